// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT FSM with branch, jump, jump-register and exception redirects.
// Optional exception-PC capture and exception entry are enabled by defining PC_EPC_EN.
module pc_sequencer #(
    parameter int unsigned  N            = 32,
    parameter int unsigned  STEP         = 4,
    parameter logic [N-1:0] RESET_VECTOR = '0,
    parameter logic [N-1:0] EXC_VECTOR   = N'(32'h8000_0180)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         branch_en,
    input  logic [15:0]  branch_imm,
    input  logic         jump_en,
    input  logic [25:0]  jump_index,
    input  logic         jr_en,
    input  logic [N-1:0] jr_target,
    input  logic         exc_req,
    input  logic         halt,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus4,
    output logic         fetch_valid,
    output logic         misaligned,
`ifdef PC_EPC_EN
    output logic [N-1:0] epc,
`endif
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_pc;
    logic         r_fetch_valid;
    logic         r_misaligned;
    logic [N-1:0] w_pc_plus4;
    logic [N-1:0] w_branch_target;
    logic [N-1:0] w_jump_target;
    logic [N-1:0] w_redirect_pc;
    logic         w_jr_misaligned;

    assign w_pc_plus4      = r_pc + N'(STEP);
    assign w_branch_target = w_pc_plus4 + {{(N-18){branch_imm[15]}}, branch_imm, 2'b00};
    assign w_jr_misaligned = jr_en && (jr_target[1:0] != 2'b00);

    // With N == 28 the jump target has no upper region bits to inherit.
    generate
        if (N > 28) begin : g_jump_region
            assign w_jump_target = {w_pc_plus4[N-1:28], jump_index, 2'b00};
        end else begin : g_jump_flat
            assign w_jump_target = {jump_index, 2'b00};
        end
    endgenerate

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_redirect_pc = w_pc_plus4;
        if (jr_en)
            w_redirect_pc = jr_target;
        else if (jump_en)
            w_redirect_pc = w_jump_target;
        else if (branch_en)
            w_redirect_pc = w_branch_target;
    end

`ifdef PC_EPC_EN
    logic [N-1:0] r_epc;
`else
    logic w_unused_exc_req;
    assign w_unused_exc_req = exc_req;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_misaligned  <= 1'b0;
`ifdef PC_EPC_EN
            r_epc         <= '0;
`endif
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    if (halt) begin
                        r_state       <= S_HALT;
                        r_fetch_valid <= 1'b0;
                    end
`ifdef PC_EPC_EN
                    else if (exc_req) begin
                        r_epc <= r_pc;
                        r_pc  <= EXC_VECTOR;
                    end
`endif
                    else if (!stall) begin
                        if (w_jr_misaligned) begin
                            r_misaligned <= 1'b1;
`ifdef PC_EPC_EN
                            r_epc        <= r_pc;
                            r_pc         <= EXC_VECTOR;
`endif
                        end else begin
                            r_pc <= w_redirect_pc;
                        end
                    end
                end
                S_HALT: begin
`ifdef PC_EPC_EN
                    if (exc_req) begin
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                        r_epc         <= r_pc;
                        r_pc          <= EXC_VECTOR;
                    end
`endif
                end
                default: begin
                    r_state       <= S_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_valid = r_fetch_valid;
    assign misaligned  = r_misaligned;
    assign state       = r_state;
`ifdef PC_EPC_EN
    assign epc         = r_epc;
`endif

endmodule
